// File: rtl/abuf_int_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : abuf_int_port_arbiter_if
// Description : Bundle of the request, memory-command and read-return
//               signals of the activation buffer internal-port arbiter.
//               The slave modport is the arbiter's view. The master modport
//               is the environment's view: requesters, buffer macro and
//               return sink.
// Ports       : clear_i                          - synchronous flush
//               rd_req_* / rd_addr_i             - read request handshake
//               wr_req_* / wr_addr_i / wr_data_i - write request handshake
//               wr_urgent_i                      - write queue near full
//               mem_*                            - buffer internal port
//               rd_data_o / rd_data_valid_o      - tagged read return
//               busy_o                           - activity indicator
// Revision    : 1.0 - initial release
// ============================================================================
interface abuf_int_port_arbiter_if #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 256
);
  logic                 clear_i;
  logic                 rd_req_valid_i;
  logic                 rd_req_ready_o;
  logic [addrWidth-1:0] rd_addr_i;
  logic                 wr_req_valid_i;
  logic                 wr_req_ready_o;
  logic [addrWidth-1:0] wr_addr_i;
  logic [dataWidth-1:0] wr_data_i;
  logic                 wr_urgent_i;
  logic                 mem_rd_en_o;
  logic [addrWidth-1:0] mem_rd_addr_o;
  logic                 mem_wr_en_o;
  logic [addrWidth-1:0] mem_wr_addr_o;
  logic [dataWidth-1:0] mem_wr_data_o;
  logic [dataWidth-1:0] mem_rd_data_i;
  logic [dataWidth-1:0] rd_data_o;
  logic                 rd_data_valid_o;
  logic                 busy_o;

  modport slave (
    input  clear_i, rd_req_valid_i, rd_addr_i, wr_req_valid_i, wr_addr_i,
           wr_data_i, wr_urgent_i, mem_rd_data_i,
    output rd_req_ready_o, wr_req_ready_o, mem_rd_en_o, mem_rd_addr_o,
           mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, rd_data_o,
           rd_data_valid_o, busy_o
  );

  modport master (
    output clear_i, rd_req_valid_i, rd_addr_i, wr_req_valid_i, wr_addr_i,
           wr_data_i, wr_urgent_i, mem_rd_data_i,
    input  rd_req_ready_o, wr_req_ready_o, mem_rd_en_o, mem_rd_addr_o,
           mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, rd_data_o,
           rd_data_valid_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/abuf_int_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : abuf_int_port_arbiter
// Description : Grants the single 256-bit activation-buffer internal port to
//               either the feature-fetch read path or the writeback path,
//               one access per cycle. Reads win by default. Writes are
//               protected by an urgent override, an age (starvation) counter
//               and a same-address read-after-write ordering rule. Read data
//               returns in order, readLatency cycles after the memory
//               command, as a single-cycle pulse.
// Ports       : clk  - clock
//               nrst - asynchronous active-low reset
//               bus  - abuf_int_port_arbiter_if.slave (requests, memory
//                      command/return, read return, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module abuf_int_port_arbiter #(
  parameter int addrWidth   = 32,
  parameter int dataWidth   = 256,
  parameter int readLatency = 1,
  parameter int starveLimit = 4
) (
  input  wire logic                clk,
  input  wire logic                nrst,
  abuf_int_port_arbiter_if.slave   bus
);

  localparam int                 C_AGE_W     = $clog2(starveLimit + 1);
  localparam logic [C_AGE_W-1:0] C_AGE_LIMIT = C_AGE_W'(starveLimit);
  localparam logic [C_AGE_W-1:0] C_AGE_ONE   = C_AGE_W'(1);

  // --------------------------------------------------------------------------
  // Grant decision (combinational)
  // --------------------------------------------------------------------------
  logic [C_AGE_W-1:0] r_age;
  logic               w_raw_hazard;
  logic               w_wr_force;
  logic               w_wr_grant;
  logic               w_rd_grant;

  always_comb begin
    w_raw_hazard = 1'b0;
    w_wr_force   = 1'b0;
    w_wr_grant   = 1'b0;
    w_rd_grant   = 1'b0;

    // Same-address collision: let the write go first so the read observes
    // the new data.
    w_raw_hazard = bus.rd_req_valid_i && bus.wr_req_valid_i &&
                   (bus.rd_addr_i == bus.wr_addr_i);

    // Conditions under which a valid write overrides a valid read.
    w_wr_force = bus.wr_urgent_i || (r_age >= C_AGE_LIMIT) || w_raw_hazard;

    if (!bus.clear_i) begin
      if (bus.wr_req_valid_i && (w_wr_force || !bus.rd_req_valid_i)) begin
        w_wr_grant = 1'b1;
      end else if (bus.rd_req_valid_i) begin
        w_rd_grant = 1'b1;
      end
    end
  end

  assign bus.rd_req_ready_o = w_rd_grant;
  assign bus.wr_req_ready_o = w_wr_grant;

  // --------------------------------------------------------------------------
  // Write age counter: counts cycles a pending write has been denied.
  // It never needs to exceed the limit, since at the limit a valid write is
  // granted (or cleared) in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_age <= '0;
    end else if (bus.clear_i || w_wr_grant || !bus.wr_req_valid_i) begin
      r_age <= '0;
    end else if (r_age != C_AGE_LIMIT) begin
      r_age <= r_age + C_AGE_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Memory command registers: enables pulse for the cycle after a grant,
  // address/data hold their last granted value.
  // --------------------------------------------------------------------------
  logic                 r_mem_rd_en;
  logic [addrWidth-1:0] r_mem_rd_addr;
  logic                 r_mem_wr_en;
  logic [addrWidth-1:0] r_mem_wr_addr;
  logic [dataWidth-1:0] r_mem_wr_data;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
    end else begin
      // Grants are already suppressed by clear, so enables drop with it.
      r_mem_rd_en <= w_rd_grant;
      r_mem_wr_en <= w_wr_grant;
      if (w_rd_grant) begin
        r_mem_rd_addr <= bus.rd_addr_i;
      end
      if (w_wr_grant) begin
        r_mem_wr_addr <= bus.wr_addr_i;
        r_mem_wr_data <= bus.wr_data_i;
      end
    end
  end

  assign bus.mem_rd_en_o   = r_mem_rd_en;
  assign bus.mem_rd_addr_o = r_mem_rd_addr;
  assign bus.mem_wr_en_o   = r_mem_wr_en;
  assign bus.mem_wr_addr_o = r_mem_wr_addr;
  assign bus.mem_wr_data_o = r_mem_wr_data;

  // --------------------------------------------------------------------------
  // Read return tracking. Stage 0 is loaded from the issued enable, so the
  // tail is high exactly in the cycle the buffer presents the data.
  // --------------------------------------------------------------------------
  logic [readLatency-1:0] r_rd_vld;
  logic                   w_rd_tail;
  logic [dataWidth-1:0]   r_rd_data_hold;

  assign w_rd_tail = r_rd_vld[readLatency-1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_vld <= '0;
    end else if (bus.clear_i) begin
      // Flush drops every in-flight return, including a command that is on
      // the memory port in this very cycle.
      r_rd_vld <= '0;
    end else begin
      r_rd_vld[0] <= r_mem_rd_en;
      for (int i = 1; i < readLatency; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
      end
    end
  end

  // Capture the returned word when the tail fires so rd_data_o keeps the
  // last delivered beat afterwards; during the tail cycle the live buffer
  // data is forwarded so the return is not delayed by an extra stage.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_data_hold <= '0;
    end else if (w_rd_tail) begin
      r_rd_data_hold <= bus.mem_rd_data_i;
    end
  end

  assign bus.rd_data_o       = w_rd_tail ? bus.mem_rd_data_i : r_rd_data_hold;
  assign bus.rd_data_valid_o = w_rd_tail;

  // --------------------------------------------------------------------------
  // Activity
  // --------------------------------------------------------------------------
  assign bus.busy_o = bus.rd_req_valid_i | bus.wr_req_valid_i |
                      r_mem_rd_en | r_mem_wr_en | (|r_rd_vld) | w_rd_tail;

endmodule
`default_nettype wire

// File: tb/tb_abuf_int_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_abuf_int_port_arbiter
// Description : Scoreboard bench for abuf_int_port_arbiter. Directed steps
//               drive one cycle each, check the readies and queue the
//               expected memory commands and read returns; an independent
//               monitor pops and compares them when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_abuf_int_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int RL = 1;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic nrst;

  always #5 clk = ~clk;

  abuf_int_port_arbiter_if #(.addrWidth(AW), .dataWidth(DW)) bus ();

  abuf_int_port_arbiter #(
    .addrWidth  (AW),
    .dataWidth  (DW),
    .readLatency(RL),
    .starveLimit(SL)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } txn_t;

  txn_t q_rd[$];
  txn_t q_wr[$];
  txn_t q_ret[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] mem     [0:127];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_data(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Buffer macro model: one-cycle read latency, write on enable.
  always @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_data(AW'(i << 5));
      bus.mem_rd_data_i <= '0;
    end else begin
      if (bus.mem_wr_en_o) mem[bus.mem_wr_addr_o[11:5]] <= bus.mem_wr_data_o;
      if (bus.mem_rd_en_o) bus.mem_rd_data_i <= mem[bus.mem_rd_addr_o[11:5]];
    end
  end

  // Monitor: pops expectations whenever the DUT presents a command/return.
  always @(negedge clk) begin
    txn_t t;
    if (nrst) begin
      if (bus.mem_rd_en_o) begin
        if (q_rd.size() == 0) chk("rd_cmd_unexpected", bus.mem_rd_en_o, 1'b0);
        else begin
          t = q_rd.pop_front();
          chk("rd_cmd_addr", bus.mem_rd_addr_o, t.addr);
          chk("rd_cmd_cycle", cyc, t.cyc);
        end
      end
      if (bus.mem_wr_en_o) begin
        if (q_wr.size() == 0) chk("wr_cmd_unexpected", bus.mem_wr_en_o, 1'b0);
        else begin
          t = q_wr.pop_front();
          chk("wr_cmd_addr", bus.mem_wr_addr_o, t.addr);
          chk("wr_cmd_data", bus.mem_wr_data_o, t.data);
          chk("wr_cmd_cycle", cyc, t.cyc);
        end
      end
      if (bus.rd_data_valid_o) begin
        if (q_ret.size() == 0) chk("ret_unexpected", bus.rd_data_valid_o, 1'b0);
        else begin
          t = q_ret.pop_front();
          chk("ret_data", bus.rd_data_o, t.data);
          chk("ret_cycle", cyc, t.cyc);
        end
      end
    end
  end

  // One directed cycle: drive, check readies, queue expected results.
  task automatic step(input bit rv, input logic [AW-1:0] ra, input bit wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit urg, input bit clr, input bit erd, input bit ewr,
                      input string tag);
    txn_t t;
    bus.rd_req_valid_i = rv;
    bus.rd_addr_i      = ra;
    bus.wr_req_valid_i = wv;
    bus.wr_addr_i      = wa;
    bus.wr_data_i      = wd;
    bus.wr_urgent_i    = urg;
    bus.clear_i        = clr;
    @(negedge clk);
    chk({tag, "_rd_rdy"}, bus.rd_req_ready_o, erd);
    chk({tag, "_wr_rdy"}, bus.wr_req_ready_o, ewr);
    if (ewr) begin
      t.addr = wa; t.data = wd; t.cyc = cyc + 1;
      q_wr.push_back(t);
      ref_mem[wa[11:5]] = wd;
    end
    if (erd) begin
      t.addr = ra; t.data = '0; t.cyc = cyc + 1;
      q_rd.push_back(t);
      t.data = ref_mem[ra[11:5]]; t.cyc = cyc + 1 + RL;
      q_ret.push_back(t);
    end
    if (clr) q_ret.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, 0, 0, 0, tag);
  endtask

  task automatic drained(input string tag);
    chk({tag, "_rd_q_empty"}, q_rd.size(), 0);
    chk({tag, "_wr_q_empty"}, q_wr.size(), 0);
    chk({tag, "_ret_q_empty"}, q_ret.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_rdy"}, bus.rd_req_ready_o, 0);
    chk({tag, "_wr_rdy"}, bus.wr_req_ready_o, 0);
    chk({tag, "_mem_rd_en"}, bus.mem_rd_en_o, 0);
    chk({tag, "_mem_rd_addr"}, bus.mem_rd_addr_o, 0);
    chk({tag, "_mem_wr_en"}, bus.mem_wr_en_o, 0);
    chk({tag, "_mem_wr_addr"}, bus.mem_wr_addr_o, 0);
    chk({tag, "_mem_wr_data"}, bus.mem_wr_data_o, 0);
    chk({tag, "_rd_data"}, bus.rd_data_o, 0);
    chk({tag, "_rd_valid"}, bus.rd_data_valid_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
  endtask

  task automatic set_inputs_idle();
    bus.rd_req_valid_i = 0; bus.rd_addr_i = '0;
    bus.wr_req_valid_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.wr_urgent_i = 0; bus.clear_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = init_data(AW'(i << 5));
    set_inputs_idle();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    nrst = 1'b1;
    @(posedge clk); #1;

    // Read only, back to back.
    step(1, 32'h00, 0, '0, '0, 0, 0, 1, 0, "rd0");
    step(1, 32'h20, 0, '0, '0, 0, 0, 1, 0, "rd1");
    step(1, 32'h40, 0, '0, '0, 0, 0, 1, 0, "rd2");
    idle(4, "rd_idle");
    drained("rd");

    // Starvation: write waits starveLimit cycles, twice in a row.
    for (int k = 0; k <= SL; k++)
      step(1, AW'(32'h200 + k * 32'h20), 1, 32'h100, {8{32'h1111_0100}},
           0, 0, k < SL, k == SL, "starve_a");
    for (int k = 0; k <= SL; k++)
      step(1, AW'(32'h2A0 + k * 32'h20), 1, 32'h120, {8{32'h2222_0120}},
           0, 0, k < SL, k == SL, "starve_b");
    idle(4, "starve_idle");
    drained("starve");

    // Urgent override, then urgent with no write valid.
    step(1, 32'h300, 1, 32'h340, {8{32'h3333_0340}}, 1, 0, 0, 1, "urg_wr");
    step(1, 32'h300, 0, '0, '0, 1, 0, 1, 0, "urg_nowr");
    // Write alone.
    step(0, '0, 1, 32'h360, {8{32'h4444_0360}}, 0, 0, 0, 1, "wr_only");
    // Different addresses, no urgency, age 0: read first.
    step(1, 32'h380, 1, 32'h3A0, {8{32'h5555_03A0}}, 0, 0, 1, 0, "rd_prio");
    step(0, '0, 1, 32'h3A0, {8{32'h5555_03A0}}, 0, 0, 0, 1, "rd_prio_wr");
    // RAW at 0x80: write first, read next cycle sees new data.
    step(1, 32'h80, 1, 32'h80, {8{32'h6666_0080}}, 0, 0, 0, 1, "raw_wr");
    step(1, 32'h80, 0, '0, '0, 0, 0, 1, 0, "raw_rd");
    step(1, 32'h360, 0, '0, '0, 0, 0, 1, 0, "wr_only_rb");
    idle(4, "urg_idle");
    drained("urg");

    // Clear: read at t, clear at t+1 drops its return.
    step(1, 32'h400, 0, '0, '0, 0, 0, 1, 0, "clr_rd");
    step(1, 32'h420, 1, 32'h440, {8{32'h7777_0440}}, 1, 1, 0, 0, "clr");
    step(0, '0, 0, '0, '0, 0, 0, 0, 0, "clr_after");
    @(negedge clk);
    chk("clr_busy", bus.busy_o, 0);
    @(posedge clk); #1;
    idle(3, "clr_idle");
    drained("clr");

    // Asynchronous reset with two reads in flight.
    step(1, 32'h500, 0, '0, '0, 0, 0, 1, 0, "arst_rd0");
    step(1, 32'h520, 0, '0, '0, 0, 0, 1, 0, "arst_rd1");
    set_inputs_idle();
    nrst = 1'b0;
    q_rd.delete(); q_wr.delete(); q_ret.delete();
    #1;
    chk_all_zero("arst");
    repeat (2) @(posedge clk);
    #3;
    nrst = 1'b1;
    @(posedge clk); #1;
    idle(3, "arst_idle");
    step(1, 32'h540, 0, '0, '0, 0, 0, 1, 0, "arst_fresh");
    idle(4, "arst_idle2");
    drained("arst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/abuf_int_port_arbiter.md
# abuf_int_port_arbiter

Arbiter and sequencer for the single shared 256-bit internal port of the activation buffer. It grants one access per cycle to one of two requesters: the controller-driven feature-fetch read path and the output write queue's writeback path. Read return data is tagged and delivered to the padder/feature-loader path with a fixed latency. Reads have priority to keep the MAC array fed. Writes are protected from starvation by an age counter, an urgent override and a same-address ordering rule.

## Interface
Parameters:
- `addrWidth`, 32, buffer byte address width
- `dataWidth`, 256, internal port data width
- `readLatency`, 1, cycles from `mem_rd_en_o` to valid `mem_rd_data_i` (≥1)
- `starveLimit`, 4, maximum cycles a valid write may be denied before it is forced through (≥1)

Ports:
- `clk`, in, 1, clock
- `nrst`, in, 1, reset, asynchronous, active-low
- `clear_i`, in, 1, synchronous flush from CSR main clear
- `rd_req_valid_i`, in, 1, read request valid
- `rd_req_ready_o`, out, 1, read request accepted this cycle
- `rd_addr_i`, in, addrWidth, read address
- `wr_req_valid_i`, in, 1, write request valid
- `wr_req_ready_o`, out, 1, write request accepted this cycle
- `wr_addr_i`, in, addrWidth, write address
- `wr_data_i`, in, dataWidth, write data
- `wr_urgent_i`, in, 1, write queue near full: write wins unconditionally
- `mem_rd_en_o`, out, 1, buffer read enable
- `mem_rd_addr_o`, out, addrWidth, buffer read address
- `mem_wr_en_o`, out, 1, buffer write enable
- `mem_wr_addr_o`, out, addrWidth, buffer write address
- `mem_wr_data_o`, out, dataWidth, buffer write data
- `mem_rd_data_i`, in, dataWidth, buffer read data
- `rd_data_o`, out, dataWidth, returned read data
- `rd_data_valid_o`, out, 1, `rd_data_o` valid
- `busy_o`, out, 1, any request pending or read in flight

## Operation
- Handshake: a request transfers when valid && ready on the same cycle. At most one of `rd_req_ready_o` / `wr_req_ready_o` is high in any cycle. Ready is combinational from the valids, the age counter, `wr_urgent_i`, the addresses and `clear_i`.
- Grant priority, highest first:
  1. `clear_i`: no grant.
  2. Write, if `wr_urgent_i`.
  3. Write, if the age counter ≥ `starveLimit`.
  4. Write, if both requests are valid and `rd_addr_i == wr_addr_i` (read-after-write ordering; the read waits and sees new data).
  5. Read, if valid.
  6. Write, if valid.
- Age counter, width clog2(starveLimit+1), saturating:
  - Increments each cycle `wr_req_valid_i` is high without a write grant.
  - Resets to 0 on a write grant, or when `wr_req_valid_i` is low.
- Memory command registers:
  - On a grant, the address (and data, for writes) is registered. The matching `mem_*_en_o` is high for exactly the next cycle.
  - Otherwise both enables are 0. Address and data registers hold their last value.
- Read return:
  - A `readLatency`-deep valid shift register is fed by `mem_rd_en_o`.
  - `rd_data_o` is `mem_rd_data_i` registered on the cycle the tail valid is set.
  - `rd_data_valid_o` is a 1-cycle pulse per read, in order. There is no backpressure on return.
- `busy_o` = `rd_req_valid_i` | `wr_req_valid_i` | any `mem_*_en_o` | any in-flight valid | `rd_data_valid_o`.
- `clear_i` (synchronous, single cycle):
  - Zeroes both readies.
  - Zeroes the age counter.
  - Zeroes the in-flight valid pipeline and next-cycle enables.
  - Causes the next-cycle `rd_data_valid_o` to be 0.
  - A command already driven this cycle completes at the memory, but its read data is dropped.

## Timing
- Reset values: `rd_req_ready_o`/`wr_req_ready_o` follow their combinational equations (0 while no request is valid). All other outputs reset to 0: enables, addresses, `mem_wr_data_o`, `rd_data_o`, `rd_data_valid_o`, `busy_o`.
- Age counter and pipeline reset to 0.
- Read accepted at cycle t:
  - `mem_rd_en_o` high at t+1.
  - `rd_data_valid_o` high at t+1+`readLatency`.
- Write accepted at cycle t: `mem_wr_en_o` high at t+1.
- Throughput: one access per cycle, back-to-back with no bubbles.
- A write held valid under continuous reads is granted no later than `starveLimit`+1 cycles after it first asserts valid.
- Asynchronous reset mid-operation: all in-flight reads are lost and no return pulse is produced after `nrst` deasserts.

## Test plan
- Read only: addresses 0x00, 0x20, 0x40 on consecutive cycles, `readLatency`=1. Expect `mem_rd_en_o` at cycles 1–3 and `rd_data_valid_o` at cycles 2–4, carrying data in address order.
- Starvation: read valid every cycle, write valid from cycle 0 to address 0x100, `starveLimit`=4. Expect reads granted at cycles 0–3, write granted at cycle 4, `mem_wr_en_o` at cycle 5, age counter reset to 0.
- Urgent and RAW:
  - Both requests valid with different addresses and `wr_urgent_i`=1: write granted first.
  - Both valid at address 0x80 with urgent low: write granted first, read granted next cycle and returns the new data.
- Clear: issue a read at t, assert `clear_i` at t+1. Expect no `rd_data_valid_o` for that read, both readies 0 at t+1, and `busy_o` back to 0 two cycles later with no requests pending.
- Reset: assert `nrst` low while two reads are in flight. Expect all outputs 0 immediately. After release, no spurious `rd_data_valid_o`, and a fresh read returns after exactly `readLatency`+1 cycles.
